mul32_iter_ctrl: RTL and testbench

MUL32_ITER_CTRL -- requirements
Module: mul32_iter_ctrl

---
 rtl/mul32_iter_ctrl.sv | 142 ++++++++++++++
 tb/tb_mul32_iter_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul32_iter_ctrl.sv
// Iterative 32x32 unsigned multiplier: one 16x16 partial-product unit reused over four phases.
// Optional macro EXACT_PP_EN swaps the approximate submod_16x16 for an exact 16x16 product.

module submod_16x16 (
    output logic [31:0] y,
    input  logic [15:0] a,
    input  logic [15:0] b
);
    // Truncated product: the a[3:0]*b[3:0] corner term is dropped.
    assign y = ((32'(a) * 32'(b[15:4])) << 4) + ((32'(a[15:4]) * 32'(b[3:0])) << 4);
endmodule

module mul32_iter_ctrl #(
    parameter int ZERO_SKIP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y,
    output logic        busy,
    output logic [15:0] op_count
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and y holds while out_valid waits.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [15:0] op_count_q, op_count_d;

    logic [15:0] pp_a;
    logic [15:0] pp_b;
    logic [31:0] pp_y;
    logic [63:0] pp_shifted;
    logic        zero_operand;

    // phase bit 0 picks the high half of a, bit 1 the high half of b.
    assign pp_a = phase_q[0] ? a_q[31:16] : a_q[15:0];
    assign pp_b = phase_q[1] ? b_q[31:16] : b_q[15:0];

`ifdef EXACT_PP_EN
    assign pp_y = 32'(pp_a) * 32'(pp_b);
`else
    submod_16x16 u_pp (
        .y (pp_y),
        .a (pp_a),
        .b (pp_b)
    );
`endif

    always_comb begin
        pp_shifted = 64'd0;
        case (phase_q)
            2'd0:    pp_shifted = {32'd0, pp_y};
            2'd1:    pp_shifted = {16'd0, pp_y, 16'd0};
            2'd2:    pp_shifted = {16'd0, pp_y, 16'd0};
            default: pp_shifted = {pp_y, 32'd0};
        endcase
    end

    assign zero_operand = (ZERO_SKIP != 0) && ((a_q == 32'd0) || (b_q == 32'd0));

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 64'd0;
                    phase_d = 2'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // A zero operand spends one cycle here with the accumulator left at zero.
                if (zero_operand) begin
                    phase_d = 2'd0;
                    state_d = DONE;
                end else begin
                    acc_d   = acc_q + pp_shifted;
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= 2'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            acc_q      <= 64'd0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            op_count_q <= op_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = acc_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul32_iter_ctrl.sv
// Bench for mul32_iter_ctrl: table of operand pairs plus reset and operand-scramble sequences.
// Expected products come from an independent 16x16 model matching the selected build.

module tb_mul32_iter_ctrl;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;
    logic        busy;
    logic [15:0] op_count;

    int n_checks;
    int n_fail;
    logic [63:0] exp_q[$];
    logic [15:0] exp_cnt;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        int          lat;
        bit          scramble;
    } vec_t;

    vec_t vecs[8];

    mul32_iter_ctrl #(.ZERO_SKIP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy),
        .op_count  (op_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pp16(input logic [15:0] x, input logic [15:0] z);
`ifdef EXACT_PP_EN
        return 32'(x) * 32'(z);
`else
        return 32'(x) * 32'(z) - 32'(x[3:0]) * 32'(z[3:0]);
`endif
    endfunction

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] z);
        logic [63:0] s;
        if (x == 32'd0 || z == 32'd0) return 64'd0;
        s = 64'(pp16(x[15:0], z[15:0]))
          + (64'(pp16(x[31:16], z[15:0])) << 16)
          + (64'(pp16(x[15:0], z[31:16])) << 16)
          + (64'(pp16(x[31:16], z[31:16])) << 32);
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver: one full operation, called at a negedge with the block idle
    task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i,
                         input int stall, input int exp_lat, input bit scramble);
        int lat;
        logic [63:0] y_hold;
        logic [63:0] exp_y;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        a        = a_i;
        b        = b_i;
        in_valid = 1'b1;
        exp_q.push_back(model(a_i, b_i));
        step();
        if (!scramble) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            check("busy_in_flight", 64'(busy), 64'd1);
            check("in_ready_in_flight", 64'(in_ready), 64'd0);
            if (scramble) begin
                a = $urandom_range(32'hFFFF_FFFF, 0);
                b = $urandom_range(32'hFFFF_FFFF, 0);
            end
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        y_hold = y;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_y_stable", y, y_hold);
            check("stall_op_count", 64'(op_count), 64'(exp_cnt));
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        check("busy_done", 64'(busy), 64'd1);
        exp_y = exp_q.pop_front();
        check("product", y, exp_y);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        check("out_valid_cleared", 64'(out_valid), 64'd0);
        check("idle_bubble_in_ready", 64'(in_ready), 64'd1);
        check("busy_cleared", 64'(busy), 64'd0);
        check("op_count", 64'(op_count), 64'(exp_cnt));
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = 16'd0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;

        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 4, 1'b0};
        vecs[1] = '{32'h0000_FFFF, 32'h0001_0001, 3, 4, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0005, 0, 1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 0, 4, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1, 4, 1'b1};
        vecs[5] = '{32'h0000_0007, 32'h0000_0000, 2, 1, 1'b0};
        vecs[6] = '{32'h0000_0001, 32'h0000_0001, 0, 4, 1'b0};
        vecs[7] = '{32'hDEAD_BEEF, 32'h0F0F_F0F0, 0, 4, 1'b1};

        step();
        step();
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_y", y, 64'd0);
        check("reset_op_count", 64'(op_count), 64'd0);

        // reset wins over an accept on the same edge
        in_valid = 1'b1;
        a        = 32'd3;
        b        = 32'd4;
        step();
        check("rst_priority_in_ready", 64'(in_ready), 64'd1);
        check("rst_priority_busy", 64'(busy), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].lat, vecs[i].scramble);
        end

        // reset mid-MUL: in-flight product is dropped, op_count cleared
        a        = 32'h0001_0000;
        b        = 32'h0001_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 16'd0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_y", y, 64'd0);
        check("mid_rst_op_count", 64'(op_count), 64'd0);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) lat++;
            step();
        end
        check("mid_rst_no_out_valid", 64'(lat), 64'd0);
        do_op(32'h0001_0000, 32'h0001_0000, 0, 4, 1'b0);

        // reset while a result waits in DONE
        a        = 32'h0000_0003;
        b        = 32'h0000_0005;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("done_before_rst", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        exp_cnt   = 16'd0;
        check("done_rst_out_valid", 64'(out_valid), 64'd0);
        check("done_rst_op_count", 64'(op_count), 64'd0);
        check("done_rst_y", y, 64'd0);

        for (int i = 0; i < 4; i++) begin
            do_op($urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 1),
                  $urandom_range(2, 0), 4, 1'b0);
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
